// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the set controller.
// Optional feature macro: SET_CONTROLLER_WRITEBACK_EN (write-back with dirty eviction).
package cache_pkg;

    localparam int unsigned DEF_NUM_WAYS      = 4;
    localparam int unsigned DEF_COUNTER_WIDTH = 8;
    localparam int unsigned DEF_ADDRESS_WIDTH = 32;
    localparam int unsigned DEF_BLOCK_SIZE    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
`ifdef SET_CONTROLLER_WRITEBACK_EN
        WRITEBACK,
`endif
        FILL,
        ALLOC,
        RESPOND
    } state_t;

endpackage

// File: rtl/victim_selector.sv
// Replacement choice: first invalid way, else first expired way, else oldest way (ties low).
module victim_selector
    import cache_pkg::*;
#(
    parameter  int unsigned NUM_WAYS      = DEF_NUM_WAYS,
    parameter  int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    localparam int unsigned WAY_IDX_W     = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]               valid,
    input  logic [NUM_WAYS-1:0]               expired,
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] age,
    output logic [WAY_IDX_W-1:0]              index
);

    logic                     inv_found;
    logic                     exp_found;
    logic [WAY_IDX_W-1:0]     inv_idx;
    logic [WAY_IDX_W-1:0]     exp_idx;
    logic [WAY_IDX_W-1:0]     old_idx;
    logic [COUNTER_WIDTH-1:0] old_age;

    // Scan ways once, keeping the lowest-index candidate for each priority class.
    always_comb begin
        inv_found = 1'b0;
        exp_found = 1'b0;
        inv_idx   = '0;
        exp_idx   = '0;
        old_idx   = '0;
        old_age   = age[0 +: COUNTER_WIDTH];
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (!valid[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = WAY_IDX_W'(i);
            end
            if (expired[i] && !exp_found) begin
                exp_found = 1'b1;
                exp_idx   = WAY_IDX_W'(i);
            end
            if (age[i*COUNTER_WIDTH +: COUNTER_WIDTH] > old_age) begin
                old_age = age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                old_idx = WAY_IDX_W'(i);
            end
        end
        index = inv_found ? inv_idx : (exp_found ? exp_idx : old_idx);
    end

endmodule

// File: rtl/set_controller.sv
// Single-set cache controller: lookup, victim eviction/fill and response sequencing.
// Optional feature macro: SET_CONTROLLER_WRITEBACK_EN (dirty victims written back);
// without it, misses go straight to FILL and write hits are written through.
module set_controller
    import cache_pkg::*;
#(
    parameter  int unsigned NUM_WAYS      = DEF_NUM_WAYS,
    parameter  int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter  int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter  int unsigned BLOCK_SIZE    = DEF_BLOCK_SIZE,
    localparam int unsigned OFFSET_WIDTH  = $clog2(BLOCK_SIZE),
    localparam int unsigned TAG_WIDTH     = ADDRESS_WIDTH - OFFSET_WIDTH,
    localparam int unsigned WAY_IDX_W     = $clog2(NUM_WAYS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr,
    input  logic                              req_write,
    input  logic [NUM_WAYS-1:0]               way_valid,
    input  logic [NUM_WAYS-1:0]               way_dirty,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]     way_tag,
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age,
    input  logic [NUM_WAYS-1:0]               way_expired,
    output logic [NUM_WAYS-1:0]               way_accessed,
    output logic [COUNTER_WIDTH-1:0]          accessed_age,
    output logic [NUM_WAYS-1:0]               way_allocate,
    output logic [NUM_WAYS-1:0]               way_wen,
    output logic [ADDRESS_WIDTH-1:0]          way_address,
    output logic                              mem_req_valid,
    output logic                              mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]          mem_req_addr,
    input  logic                              mem_ack,
    output logic                              resp_valid,
    output logic                              resp_hit,
    output logic [WAY_IDX_W-1:0]              resp_way
);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     write_q;
    logic [WAY_IDX_W-1:0]     victim_q;
    logic                     resp_hit_q;
    logic [WAY_IDX_W-1:0]     resp_way_q;

    logic                     hit;
    logic [WAY_IDX_W-1:0]     hit_idx;
    logic [WAY_IDX_W-1:0]     victim_idx;
    logic [WAY_IDX_W-1:0]     sel_idx;
    logic [COUNTER_WIDTH-1:0] sel_age;
    logic [TAG_WIDTH-1:0]     req_tag;

    assign req_tag     = addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH];
    assign way_address = addr_q;

`ifdef SET_CONTROLLER_WRITEBACK_EN
    logic [TAG_WIDTH-1:0] victim_tag;
    logic [TAG_WIDTH-1:0] victim_tag_q;

    // Tag of the chosen victim, captured so the write-back address is stable.
    always_comb begin
        victim_tag = '0;
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (WAY_IDX_W'(i) == victim_idx) victim_tag = way_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    // Victim tag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  victim_tag_q <= '0;
        else if (state == LOOKUP) victim_tag_q <= victim_tag;
    end
`else
    logic unused_dirty;
    assign unused_dirty = ^way_dirty;
`endif

    // Tag match against the latched request; the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (!hit && way_valid[i] && (way_tag[i*TAG_WIDTH +: TAG_WIDTH] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = WAY_IDX_W'(i);
            end
        end
    end

    // Age of the way being touched: the hit way in LOOKUP, the victim in ALLOC.
    always_comb begin
        sel_idx = (state == ALLOC) ? victim_q : hit_idx;
        sel_age = '0;
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (WAY_IDX_W'(i) == sel_idx) sel_age = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        end
    end

    victim_selector #(
        .NUM_WAYS      (NUM_WAYS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_victim (
        .valid   (way_valid),
        .expired (way_expired),
        .age     (way_age),
        .index   (victim_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request and lookup-result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            victim_q   <= '0;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
        end else if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
        end else if (state == LOOKUP) begin
            victim_q   <= victim_idx;
            resp_hit_q <= hit;
            resp_way_q <= hit ? hit_idx : victim_idx;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        way_accessed  = '0;
        accessed_age  = '0;
        way_allocate  = '0;
        way_wen       = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_way      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    way_accessed = NUM_WAYS'(1) << hit_idx;
                    accessed_age = sel_age;
                    if (write_q) way_wen = NUM_WAYS'(1) << hit_idx;
`ifndef SET_CONTROLLER_WRITEBACK_EN
                    if (write_q) begin
                        mem_req_valid = 1'b1;
                        mem_req_write = 1'b1;
                        mem_req_addr  = {req_tag, OFFSET_WIDTH'(0)};
                    end
`endif
                    state_nxt = RESPOND;
                end else begin
`ifdef SET_CONTROLLER_WRITEBACK_EN
                    if (way_valid[victim_idx] && way_dirty[victim_idx]) state_nxt = WRITEBACK;
                    else                                                  state_nxt = FILL;
`else
                    state_nxt = FILL;
`endif
                end
            end
`ifdef SET_CONTROLLER_WRITEBACK_EN
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {victim_tag_q, OFFSET_WIDTH'(0)};
                if (mem_ack) state_nxt = FILL;
            end
`endif
            FILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, OFFSET_WIDTH'(0)};
                if (mem_ack) state_nxt = ALLOC;
            end
            ALLOC: begin
                way_allocate = NUM_WAYS'(1) << victim_q;
                way_accessed = NUM_WAYS'(1) << victim_q;
                if (write_q) way_wen = NUM_WAYS'(1) << victim_q;
                accessed_age = sel_age;
                state_nxt    = RESPOND;
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_hit   = resp_hit_q;
                resp_way   = resp_way_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_set_controller.sv
// Directed bench for set_controller; expectations follow SET_CONTROLLER_WRITEBACK_EN.
module tb_set_controller;

    localparam int unsigned NW = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned TW = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              req_write;
    logic [NW-1:0]     way_valid;
    logic [NW-1:0]     way_dirty;
    logic [NW-1:0][TW-1:0] tags;
    logic [NW-1:0][CW-1:0] ages;
    logic [NW-1:0]     way_expired;
    logic [NW-1:0]     way_accessed;
    logic [CW-1:0]     accessed_age;
    logic [NW-1:0]     way_allocate;
    logic [NW-1:0]     way_wen;
    logic [AW-1:0]     way_address;
    logic              mem_req_valid;
    logic              mem_req_write;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_ack;
    logic              resp_valid;
    logic              resp_hit;
    logic [1:0]        resp_way;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    set_controller dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .way_valid    (way_valid),
        .way_dirty    (way_dirty),
        .way_tag      (tags),
        .way_age      (ages),
        .way_expired  (way_expired),
        .way_accessed (way_accessed),
        .accessed_age (accessed_age),
        .way_allocate (way_allocate),
        .way_wen      (way_wen),
        .way_address  (way_address),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_req_addr (mem_req_addr),
        .mem_ack      (mem_ack),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle accept pulse; returns with the DUT in LOOKUP.
    task automatic request(input logic [AW-1:0] addr, input logic wr);
        req_addr  = addr;
        req_write = wr;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        way_valid = '0; way_dirty = '0; tags = '0; ages = '0; way_expired = '0; mem_ack = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_addr", way_address, 0);
        check("rst_memv", mem_req_valid, 0);
        check("rst_resp", resp_valid, 0);
        tick(); rst = 1'b0; tick();

        // Read hit on way2
        way_valid = 4'b0100; tags[2] = 27'h1234; ages[2] = 8'd5;
        request(32'h0002_4680, 1'b0);
        check("hit_acc", way_accessed, 4'b0100);
        check("hit_age", accessed_age, 5);
        check("hit_wen", way_wen, 0);
        check("hit_memv", mem_req_valid, 0);
        check("hit_resp_early", resp_valid, 0);
        tick();
        check("hit_resp", resp_valid, 1);
        check("hit_rhit", resp_hit, 1);
        check("hit_rway", resp_way, 2);
        tick();
        check("hit_idle", req_ready, 1);
        check("hit_resp_off", resp_valid, 0);

        // Multiple matches: lowest index wins
        way_valid = 4'b1010; tags[1] = 27'h1234; tags[3] = 27'h1234; ages[1] = 8'd11;
        request(32'h0002_4680, 1'b0);
        check("multi_acc", way_accessed, 4'b0010);
        check("multi_age", accessed_age, 11);
        tick(); tick();

        // Invalid victim, write miss; offset bits must be dropped from the fill address
        way_valid = 4'b1011; tags = {27'h103, 27'h102, 27'h101, 27'h100};
        ages = {8'd4, 8'd6, 8'd2, 8'd1};
        request(32'h0000_0AA7, 1'b1);
        check("inv_lookup_acc", way_accessed, 0);
        check("inv_lookup_memv", mem_req_valid, 0);
        check("inv_wayaddr", way_address, 32'h0000_0AA7);
        tick();
        check("inv_fill_v", mem_req_valid, 1);
        check("inv_fill_w", mem_req_write, 0);
        check("inv_fill_a", mem_req_addr, 32'h0000_0AA0);
        tick();
        check("inv_fill_hold", mem_req_valid, 1);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("inv_alloc", way_allocate, 4'b0100);
        check("inv_alloc_acc", way_accessed, 4'b0100);
        check("inv_alloc_wen", way_wen, 4'b0100);
        check("inv_alloc_age", accessed_age, 6);
        check("inv_alloc_memv", mem_req_valid, 0);
        tick();
        check("inv_resp", resp_valid, 1);
        check("inv_rhit", resp_hit, 0);
        check("inv_rway", resp_way, 2);
        tick();

        // Dirty victim: oldest with tie to lowest index is way1
        way_valid = 4'b1111; way_dirty = 4'b0010;
        tags = {27'h203, 27'h202, 27'h201, 27'h200};
        ages = {8'd1, 8'd9, 8'd9, 8'd3};
        request(32'h0000_0EE0, 1'b0);
        tick();
`ifdef SET_CONTROLLER_WRITEBACK_EN
        check("dirty_wb_v", mem_req_valid, 1);
        check("dirty_wb_w", mem_req_write, 1);
        check("dirty_wb_a", mem_req_addr, 32'h0000_4020);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
`endif
        check("dirty_fill_v", mem_req_valid, 1);
        check("dirty_fill_w", mem_req_write, 0);
        check("dirty_fill_a", mem_req_addr, 32'h0000_0EE0);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("dirty_alloc", way_allocate, 4'b0010);
        check("dirty_alloc_wen", way_wen, 0);
        check("dirty_alloc_age", accessed_age, 9);
        tick();
        check("dirty_rway", resp_way, 1);
        tick();
        way_dirty = '0;

        // Expired way beats the oldest way
        ages = {8'd4, 8'd7, 8'd2, 8'd1}; way_expired = 4'b0001;
        request(32'h0000_1320, 1'b0);
        tick();
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("exp_alloc", way_allocate, 4'b0001);
        check("exp_alloc_age", accessed_age, 1);
        tick();
        check("exp_rway", resp_way, 0);
        tick();
        way_expired = '0;

        // Write hit
        way_valid = 4'b0100; tags[2] = 27'h1234; ages[2] = 8'd5;
        request(32'h0002_4680, 1'b1);
        check("wh_wen", way_wen, 4'b0100);
`ifdef SET_CONTROLLER_WRITEBACK_EN
        check("wh_memv", mem_req_valid, 0);
`else
        check("wh_memv", mem_req_valid, 1);
        check("wh_memw", mem_req_write, 1);
        check("wh_mema", mem_req_addr, 32'h0002_4680);
`endif
        tick();
        check("wh_memv_off", mem_req_valid, 0);
        check("wh_resp", resp_valid, 1);
        tick();

        // Reset mid-FILL abandons the memory request
        way_valid = 4'b0000;
        request(32'h0000_0AA0, 1'b0);
        tick();
        check("rf_fill_v", mem_req_valid, 1);
        rst = 1'b1; #1;
        check("rf_memv", mem_req_valid, 0);
        check("rf_ready", req_ready, 1);
        check("rf_addr", way_address, 0);
        @(negedge clk); rst = 1'b0; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        check("rf_ack_ready", req_ready, 1);
        check("rf_ack_alloc", way_allocate, 0);
        check("rf_ack_memv", mem_req_valid, 0);
        tick();
        check("rf_ack_resp", resp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
